// File: rtl/vram_fill_engine_pkg.sv
// ---------------------------------------------------------------------------
// vga_fill_pkg
// Shared definitions for the VRAM rectangle fill engine: register offsets,
// CTRL bit positions, default geometry (row stride, address width, address
// XOR) and the fill FSM state encoding.
// Optional feature macro used by the engine: VRAM_FILL_INCR_EN.
// ---------------------------------------------------------------------------
package vga_fill_pkg;

   localparam int unsigned STRIDE_DEF = 100;
   localparam int unsigned AW_DEF     = 13;
   localparam logic [12:0] ADDR_XOR_DEF = 13'h1000;

   // CPU register offsets
   localparam logic [2:0] REG_DST_LO = 3'd0;
   localparam logic [2:0] REG_DST_HI = 3'd1;
   localparam logic [2:0] REG_WIDTH  = 3'd2;
   localparam logic [2:0] REG_HEIGHT = 3'd3;
   localparam logic [2:0] REG_VALUE  = 3'd4;
   localparam logic [2:0] REG_CTRL   = 3'd5;

   // CTRL write bits
   localparam int CTRL_START   = 0;
   localparam int CTRL_IRQ_CLR = 1;
   localparam int CTRL_IRQ_EN  = 7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WR       = 2'd2,
      ST_NEXT_ROW = 2'd3
   } fill_state_e;

endpackage

// File: rtl/vram_fill_engine_if.sv
// ---------------------------------------------------------------------------
// vram_fill_engine_if
// Bundles the CPU register port (sel_blt/we/addr/din/dout), the VRAM bus
// handshake (bus_req/bus_gnt), the VRAM write port (m_sel_ram/m_we/m_addr/
// m_din) and the fill-complete interrupt (irq).
//   master : the fill engine's view (drives dout, bus_req, m_*, irq)
//   slave  : the system's view (drives CPU port and bus_gnt)
// ---------------------------------------------------------------------------
interface vram_fill_engine_if #(
   parameter int unsigned AW = 13
);
   logic          sel_blt;
   logic          we;
   logic [2:0]    addr;
   logic [7:0]    din;
   logic [7:0]    dout;
   logic          bus_req;
   logic          bus_gnt;
   logic          m_sel_ram;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_din;
   logic          irq;

   modport master (
      input  sel_blt, we, addr, din, bus_gnt,
      output dout, bus_req, m_sel_ram, m_we, m_addr, m_din, irq
   );

   modport slave (
      output sel_blt, we, addr, din, bus_gnt,
      input  dout, bus_req, m_sel_ram, m_we, m_addr, m_din, irq
   );
endinterface

// File: rtl/vram_fill_engine_addr_gen.sv
// ---------------------------------------------------------------------------
// vram_fill_addr_gen
// Column/row walker for the fill rectangle. Holds the current row base
// address, column and row counters, flags the last column/row and produces
// the VRAM address (base + col) ^ ADDR_XOR, all mod 2^AW.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   load_i              start of fill: base = dst_i, col = row = 0
//   step_i              a cell was written this cycle: col++
//   next_row_i          row change bubble: base += STRIDE, col = 0, row++
//   dst_i               first cell of the rectangle
//   width_i, height_i   rectangle size (both non-zero while a fill runs)
//   last_col_o          current column is the last of the row
//   last_row_o          current row is the last of the rectangle
//   addr_o              VRAM address for the current cell
// ---------------------------------------------------------------------------
module vram_fill_addr_gen #(
   parameter int unsigned   STRIDE   = 100,
   parameter int unsigned   AW       = 13,
   parameter logic [AW-1:0] ADDR_XOR = 13'h1000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic          step_i,
   input  logic          next_row_i,
   input  logic [AW-1:0] dst_i,
   input  logic [7:0]    width_i,
   input  logic [7:0]    height_i,
   output logic          last_col_o,
   output logic          last_row_o,
   output logic [AW-1:0] addr_o
);

   localparam logic [AW-1:0] STRIDE_W = AW'(STRIDE);

   logic [AW-1:0] base_q, base_d;
   logic [7:0]    col_q, col_d;
   logic [7:0]    row_q, row_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q <= '0;
         col_q  <= 8'h00;
         row_q  <= 8'h00;
      end else begin
         base_q <= base_d;
         col_q  <= col_d;
         row_q  <= row_d;
      end
   end

   always_comb begin
      base_d = base_q;
      col_d  = col_q;
      row_d  = row_q;
      if (load_i) begin
         base_d = dst_i;
         col_d  = 8'h00;
         row_d  = 8'h00;
      end else if (next_row_i) begin
         base_d = base_q + STRIDE_W;
         col_d  = 8'h00;
         row_d  = row_q + 8'd1;
      end else if (step_i) begin
         col_d  = col_q + 8'd1;
      end
   end

   assign last_col_o = (col_q == width_i - 8'd1);
   assign last_row_o = (row_q == height_i - 8'd1);
   assign addr_o     = (base_q + AW'(col_q)) ^ ADDR_XOR;

endmodule

// File: rtl/vram_fill_engine.sv
// ---------------------------------------------------------------------------
// vram_fill_engine
// CPU-programmed rectangle fill for the 100-column video RAM. After a CTRL
// start it requests the VRAM write port and, while granted, writes one byte
// per clock over a WIDTH x HEIGHT block, with one idle bubble between rows.
// Ports:
//   clk     sole clock
//   reset   asynchronous active-high reset
//   bus     vram_fill_engine_if.master: CPU register port, bus_req/bus_gnt,
//           VRAM write port and level irq
// Registers: 0 DST_LO, 1 DST_HI[4:0], 2 WIDTH, 3 HEIGHT, 4 VALUE,
//   5 CTRL (write: b0 start, b1 irq clear, b7 irq_en;
//           read: {irq_en, done, 4'b0, irq, busy}); 6-7 read 0.
// Build option: define VRAM_FILL_INCR_EN to write VALUE + (write count mod
// 256) instead of a constant VALUE.
// ---------------------------------------------------------------------------
module vram_fill_engine
   import vga_fill_pkg::*;
#(
   parameter int unsigned   STRIDE   = STRIDE_DEF,
   parameter int unsigned   AW       = AW_DEF,
   parameter logic [AW-1:0] ADDR_XOR = ADDR_XOR_DEF
) (
   input logic                clk,
   input logic                reset,
   vram_fill_engine_if.master bus
);

   fill_state_e state_q, state_d;

   logic [7:0] dst_lo_q, width_q, height_q, value_q, dout_q;
   logic [4:0] dst_hi_q;
   logic       irq_en_q, irq_en_d;
   logic       done_q, done_d;
   logic       irq_q, irq_d;

   logic          reg_wr, reg_rd, ctrl_wr, busy;
   logic          start_ok, start_nil, wr_fire, last_wr;
   logic          ag_load, ag_step, ag_next_row;
   logic          last_col, last_row;
   logic [AW-1:0] cell_addr, dst;
   logic [7:0]    wdata;

   assign reg_wr  = bus.sel_blt & bus.we;
   assign reg_rd  = bus.sel_blt & ~bus.we;
   assign ctrl_wr = reg_wr && (bus.addr == REG_CTRL);
   assign busy    = (state_q != ST_IDLE);
   assign dst     = AW'({dst_hi_q, dst_lo_q});

   // A start with an empty rectangle completes on the spot without the bus.
   assign start_ok  = ctrl_wr && bus.din[CTRL_START] && !busy &&
                      (width_q != 8'h00) && (height_q != 8'h00);
   assign start_nil = ctrl_wr && bus.din[CTRL_START] && !busy &&
                      ((width_q == 8'h00) || (height_q == 8'h00));

   // A cell is written only in WR while the grant is held; dropping the
   // grant freezes the walker so nothing is skipped or repeated.
   assign wr_fire = (state_q == ST_WR) && bus.bus_gnt;
   assign last_wr = wr_fire && last_col && last_row;

   vram_fill_addr_gen #(
      .STRIDE   (STRIDE),
      .AW       (AW),
      .ADDR_XOR (ADDR_XOR)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ag_load),
      .step_i     (ag_step),
      .next_row_i (ag_next_row),
      .dst_i      (dst),
      .width_i    (width_q),
      .height_i   (height_q),
      .last_col_o (last_col),
      .last_row_o (last_row),
      .addr_o     (cell_addr)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      ag_load     = 1'b0;
      ag_step     = 1'b0;
      ag_next_row = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               ag_load = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.bus_gnt) state_d = ST_WR;
         end
         ST_WR: begin
            if (bus.bus_gnt) begin
               ag_step = 1'b1;
               if (last_col) state_d = last_row ? ST_IDLE : ST_NEXT_ROW;
            end
         end
         ST_NEXT_ROW: begin
            ag_next_row = 1'b1;
            state_d     = ST_WR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- write data ----------------
`ifdef VRAM_FILL_INCR_EN
   logic [7:0] wcnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         wcnt_q <= 8'h00;
      else if (start_ok) wcnt_q <= 8'h00;
      else if (wr_fire)  wcnt_q <= wcnt_q + 8'd1;
   end

   assign wdata = value_q + wcnt_q;
`else
   assign wdata = value_q;
`endif

   // ---------------- status / irq ----------------
   always_comb begin
      irq_en_d = irq_en_q;
      done_d   = done_q;
      irq_d    = irq_q;
      if (ctrl_wr) irq_en_d = bus.din[CTRL_IRQ_EN];
      if (start_ok) done_d = 1'b0;
      if (start_nil || last_wr) done_d = 1'b1;
      if (ctrl_wr && bus.din[CTRL_IRQ_CLR]) irq_d = 1'b0;
      // set after clear so a simultaneous completion wins
      if ((start_nil || last_wr) && irq_en_d) irq_d = 1'b1;
   end

   // ---------------- register file ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dst_lo_q <= 8'h00;
         dst_hi_q <= 5'h00;
         width_q  <= 8'h00;
         height_q <= 8'h00;
         value_q  <= 8'h00;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         irq_q    <= 1'b0;
         dout_q   <= 8'h00;
      end else begin
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         irq_q    <= irq_d;
         if (reg_wr && !busy) begin
            case (bus.addr)
               REG_DST_LO: dst_lo_q <= bus.din;
               REG_DST_HI: dst_hi_q <= bus.din[4:0];
               REG_WIDTH:  width_q  <= bus.din;
               REG_HEIGHT: height_q <= bus.din;
               REG_VALUE:  value_q  <= bus.din;
               default: ;
            endcase
         end
         if (reg_rd) begin
            case (bus.addr)
               REG_DST_LO: dout_q <= dst_lo_q;
               REG_DST_HI: dout_q <= {3'b000, dst_hi_q};
               REG_WIDTH:  dout_q <= width_q;
               REG_HEIGHT: dout_q <= height_q;
               REG_VALUE:  dout_q <= value_q;
               REG_CTRL:   dout_q <= {irq_en_q, done_q, 4'b0000, irq_q, busy};
               default:    dout_q <= 8'h00;
            endcase
         end
      end
   end

   // ---------------- outputs ----------------
   assign bus.dout      = dout_q;
   assign bus.bus_req   = busy;
   assign bus.m_sel_ram = wr_fire;
   assign bus.m_we      = wr_fire;
   assign bus.m_addr    = wr_fire ? cell_addr : '0;
   assign bus.m_din     = wr_fire ? wdata : 8'h00;
   assign bus.irq       = irq_q;

endmodule
